ca90_item_gen: RTL and testbench

- Sequential CA90 item-memory generator. Latches a seed, then iterates the CA90 rule once per item: next = rotl(v, s) XOR rotr(v, s).
- Streams up to MaxItems hypervectors over a valid/ready interface.
- Feeds the item memory fill path, so a full codebook comes from one seed instead of being stored.

---
 rtl/ca90_pkg.sv | 13 +
 rtl/ca90_step.sv | 24 ++
 rtl/ca90_item_gen.sv | 132 +++++++++++++
 tb/tb_ca90_item_gen.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/ca90_pkg.sv
// Shared types and default sizing for the CA90 item-memory generator.
package ca90_pkg;

    typedef enum logic {
        IDLE,
        RUN
    } gen_state_e;

    localparam int CA90_DEFAULT_DIM       = 512;
    localparam int CA90_DEFAULT_MAX_SHIFT = 128;
    localparam int CA90_DEFAULT_MAX_ITEMS = 1024;

endpackage

// File: rtl/ca90_step.sv
// One CA90 rule step: rotl(v, s) ^ rotr(v, s), rotate amount taken mod Dimension.
module ca90_step #(
    parameter int Dimension  = 512,
    parameter int ShiftWidth = 7
) (
    input  logic [Dimension-1:0]  vec_i,
    input  logic [ShiftWidth-1:0] shift_i,
    output logic [Dimension-1:0]  vec_o
);

    logic [31:0]          amt;
    logic [31:0]          inv;
    logic [Dimension-1:0] rotl;
    logic [Dimension-1:0] rotr;

    assign amt = 32'(shift_i) % 32'(Dimension);
    assign inv = 32'(Dimension) - amt;

    // A shift by the full width yields zero, so amt=0 degenerates cleanly to v.
    assign rotl  = (vec_i << amt) | (vec_i >> inv);
    assign rotr  = (vec_i >> amt) | (vec_i << inv);
    assign vec_o = rotl ^ rotr;

endmodule

// File: rtl/ca90_item_gen.sv
// Streams a CA90 codebook from one seed over valid/ready.
// Optional: CA90_ITEM_GEN_SEED_FIRST_EN emits the seed itself as item 0.
module ca90_item_gen
    import ca90_pkg::*;
#(
    parameter int Dimension   = CA90_DEFAULT_DIM,
    parameter int MaxShiftAmt = CA90_DEFAULT_MAX_SHIFT,
    parameter int MaxItems    = CA90_DEFAULT_MAX_ITEMS,
    parameter int ShiftWidth  = $clog2(MaxShiftAmt),
    parameter int CountWidth  = $clog2(MaxItems + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  clear_i,
    input  logic [Dimension-1:0]  seed_i,
    input  logic [ShiftWidth-1:0] shift_amt_i,
    input  logic [CountWidth-1:0] num_items_i,
    output logic [Dimension-1:0]  item_o,
    output logic                  item_valid_o,
    input  logic                  item_ready_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [CountWidth-1:0] item_idx_o
);

    gen_state_e            state_q, state_d;
    logic [Dimension-1:0]  item_q, item_d;
    logic [CountWidth-1:0] idx_q, idx_d;
    logic [CountWidth-1:0] rem_q, rem_d;
    logic [ShiftWidth-1:0] shift_q, shift_d;
    logic                  done_q, done_d;

    logic [Dimension-1:0]  step_in;
    logic [Dimension-1:0]  step_out;
    logic [ShiftWidth-1:0] step_shift;
    logic [Dimension-1:0]  first_item;
    logic [CountWidth-1:0] n_sat;
    logic                  idle;

    assign idle = (state_q == IDLE);

    // While idle the step works on the live seed/shift so item 0 is ready next cycle.
    assign step_in    = idle ? seed_i : item_q;
    assign step_shift = idle ? shift_amt_i : shift_q;

    ca90_step #(
        .Dimension (Dimension),
        .ShiftWidth(ShiftWidth)
    ) u_step (
        .vec_i  (step_in),
        .shift_i(step_shift),
        .vec_o  (step_out)
    );

`ifdef CA90_ITEM_GEN_SEED_FIRST_EN
    assign first_item = seed_i;
`else
    assign first_item = step_out;
`endif

    assign n_sat = (num_items_i > CountWidth'(MaxItems))
                 ? CountWidth'(MaxItems) : num_items_i;

    always_comb begin
        state_d = state_q;
        item_d  = item_q;
        idx_d   = idx_q;
        rem_d   = rem_q;
        shift_d = shift_q;
        done_d  = 1'b0;
        if (clear_i) begin
            state_d = IDLE;
            rem_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        if (n_sat == '0) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = RUN;
                            shift_d = shift_amt_i;
                            rem_d   = n_sat;
                            idx_d   = '0;
                            item_d  = first_item;
                        end
                    end
                end
                RUN: begin
                    if (item_ready_i) begin
                        if (rem_q > CountWidth'(1)) begin
                            item_d = step_out;
                            idx_d  = idx_q + CountWidth'(1);
                            rem_d  = rem_q - CountWidth'(1);
                        end else begin
                            state_d = IDLE;
                            rem_d   = '0;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            item_q  <= '0;
            idx_q   <= '0;
            rem_q   <= '0;
            shift_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            item_q  <= item_d;
            idx_q   <= idx_d;
            rem_q   <= rem_d;
            shift_q <= shift_d;
            done_q  <= done_d;
        end
    end

    assign item_o       = item_q;
    assign item_valid_o = (state_q == RUN);
    assign busy_o       = (state_q == RUN);
    assign done_o       = done_q;
    assign item_idx_o   = idx_q;

endmodule

// File: tb/tb_ca90_item_gen.sv
// Directed self-checking bench for ca90_item_gen at Dimension=8.
module tb_ca90_item_gen;

    localparam int D  = 8;
    localparam int MS = 8;
    localparam int MI = 16;
    localparam int SW = $clog2(MS);
    localparam int CW = $clog2(MI + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          clear = 1'b0;
    logic [D-1:0]  seed = '0;
    logic [SW-1:0] shift = '0;
    logic [CW-1:0] num = '0;
    logic [D-1:0]  item;
    logic          valid;
    logic          ready = 1'b1;
    logic          busy;
    logic          done;
    logic [CW-1:0] idx;

    int n_checks = 0;
    int n_fail   = 0;
    int hs_total = 0;
    int hs_mark;
    bit seen;

    logic [7:0] e[3];
    logic [7:0] r03;
    logic [7:0] z5a [2];

    ca90_item_gen #(
        .Dimension  (D),
        .MaxShiftAmt(MS),
        .MaxItems   (MI)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .clear_i     (clear),
        .seed_i      (seed),
        .shift_amt_i (shift),
        .num_items_i (num),
        .item_o      (item),
        .item_valid_o(valid),
        .item_ready_i(ready),
        .busy_o      (busy),
        .done_o      (done),
        .item_idx_o  (idx)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (!rst && valid && ready) hs_total <= hs_total + 1;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [7:0] s, input int sh, input int n);
        seed  = s;
        shift = SW'(sh);
        num   = CW'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
`ifdef CA90_ITEM_GEN_SEED_FIRST_EN
        e[0] = 8'h01; e[1] = 8'h82; e[2] = 8'h44;
        r03 = 8'h03;
        z5a[0] = 8'h5A; z5a[1] = 8'h00;
`else
        e[0] = 8'h82; e[1] = 8'h44; e[2] = 8'hAA;
        r03 = 8'h87;
        z5a[0] = 8'h00; z5a[1] = 8'h00;
`endif
        #2;
        check("rst_item", item, 0);
        check("rst_valid", valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_idx", idx, 0);
        tick();
        rst = 1'b0;
        tick();

        // basic 3-item run, then restart on the done cycle
        hs_mark = hs_total;
        go(8'h01, 1, 3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("run_item%0d", i), item, e[i]);
            check($sformatf("run_valid%0d", i), valid, 1);
            check($sformatf("run_idx%0d", i), idx, i);
            check($sformatf("run_busy%0d", i), busy, 1);
            check($sformatf("run_done%0d", i), done, 0);
            tick();
        end
        check("end_valid", valid, 0);
        check("end_busy", busy, 0);
        check("end_done", done, 1);
        check("run_hs", hs_total - hs_mark, 3);
        go(8'h03, 1, 1);
        check("restart_valid", valid, 1);
        check("restart_item", item, r03);
        check("restart_done", done, 0);
        tick();
        check("restart_end", done, 1);
        tick();
        check("done_oneshot", done, 0);

        // backpressure at idx 1
        hs_mark = hs_total;
        go(8'h01, 1, 3);
        tick();
        ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("stall_item", item, e[1]);
            check("stall_valid", valid, 1);
            check("stall_idx", idx, 1);
            tick();
        end
        ready = 1'b1;
        check("stall_hold", item, e[1]);
        tick();
        check("stall_next", item, e[2]);
        check("stall_idx2", idx, 2);
        tick();
        check("stall_done", done, 1);
        check("stall_hs", hs_total - hs_mark, 3);
        tick();

        // zero items
        hs_mark = hs_total;
        go(8'h01, 1, 0);
        check("zero_done", done, 1);
        check("zero_valid", valid, 0);
        check("zero_busy", busy, 0);
        tick();
        check("zero_done2", done, 0);
        check("zero_valid2", valid, 0);
        check("zero_hs", hs_total - hs_mark, 0);

        // clear beats start and handshake
        go(8'h01, 1, 5);
        tick();
        check("clr_pre", item, e[1]);
        clear = 1'b1;
        start = 1'b1;
        tick();
        clear = 1'b0;
        start = 1'b0;
        check("clr_valid", valid, 0);
        check("clr_busy", busy, 0);
        check("clr_done", done, 0);
        check("clr_item", item, e[1]);
        tick();
        check("clr_done2", done, 0);
        check("clr_busy2", busy, 0);
        go(8'h03, 1, 1);
        check("clr_new_item", item, r03);
        check("clr_new_idx", idx, 0);
        tick();
        tick();

        // async reset between edges
        go(8'h01, 1, 3);
        tick();
        #2 rst = 1'b1;
        #1;
        check("arst_valid", valid, 0);
        check("arst_busy", busy, 0);
        check("arst_item", item, 0);
        check("arst_idx", idx, 0);
        check("arst_done", done, 0);
        tick();
        rst = 1'b0;
        tick();
        check("arst_nodone", done, 0);

        // shift of zero
        go(8'h5A, 0, 2);
        check("s0_item0", item, z5a[0]);
        tick();
        check("s0_item1", item, z5a[1]);
        check("s0_idx1", idx, 1);
        tick();
        check("s0_done", done, 1);
        tick();

        // saturation plus ignored start while busy
        hs_mark = hs_total;
        go(8'h01, 1, 20);
        tick();
        seed  = 8'hFF;
        num   = CW'(2);
        start = 1'b1;
        tick();
        start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            if (done) seen = 1'b1;
            else tick();
        end
        check("sat_seen_done", seen, 1);
        check("sat_hs", hs_total - hs_mark, 16);
        check("sat_last_idx", idx, 15);
        tick();
        check("sat_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
